eth_rx_parser: RTL

Per-port receive front end that sits directly upstream of the L2 switch core. It consumes the byte stream from one PHY RX path (preamble/SFD already stripped), checks FCS and length, and writes the payload bytes (FCS stripped, delimiter on the last byte) into the body FIFO. It then writes one 128-bit header word into the header FIFO in the exact layout the switch core decodes. Control frames are diverted: they are flagged and never written to the switch FIFOs.

---
 rtl/eth_rx_parser.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_parser.sv
// Ethernet RX front end: checks FCS/length/PHY errors, streams the payload to the body
// FIFO (FCS stripped, delimiter on last byte) and writes one header word per frame.
module eth_rx_parser #(
  parameter int PORT_ID       = 0,
  parameter int HEADER_DWIDTH = 128,
  parameter int MIN_FRAME     = 64,
  parameter int MAX_FRAME     = 1518
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_dv,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  input  logic                     rx_er,
  output logic [HEADER_DWIDTH-1:0] h_fifo_din,
  output logic                     h_fifo_wren,
  input  logic                     h_fifo_full,
  output logic [7:0]               b_fifo_din,
  output logic                     b_fifo_del_in,
  output logic                     b_fifo_wren,
  input  logic                     b_fifo_afull,
  output logic                     ctrl_frame,
  output logic                     drop_frame
);

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [43:0] CTRL_DST_HI = 44'h0180_C200_000;
  localparam logic [1:0]  PORT        = 2'(PORT_ID);

  typedef enum logic [2:0] {
    S_WAIT_IDLE, S_IDLE, S_HDR, S_BODY, S_FLUSH, S_HWRITE, S_DROP
  } state_t;

  state_t       state_reg, state_next;
  logic [111:0] hdr_reg;
  logic [10:0]  cnt_reg;
  logic [31:0]  crc_reg;
  logic         er_reg, ctrl_reg;
  logic [7:0]   line_reg [5];
  logic [2:0]   line_cnt_reg;

  logic admit, start, take, line_full, frame_valid;
  logic [HEADER_DWIDTH-1:0] h_din_next;
  logic [7:0] b_din_next;
  logic h_wren_next, b_wren_next, b_del_next, ctrl_next, drop_next;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int k = 0; k < 8; k++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  // A frame may also start in S_HWRITE: the inter-frame gap lets the next rise land there.
  assign admit       = !h_fifo_full && !b_fifo_afull;
  assign start       = rx_dv && admit && (state_reg == S_IDLE || state_reg == S_HWRITE);
  assign take        = rx_dv && rx_valid && (start || state_reg == S_HDR || state_reg == S_BODY);
  assign line_full   = (line_cnt_reg == 3'd5);
  assign frame_valid = (crc_reg == CRC_RESIDUE) && !er_reg &&
                       (cnt_reg >= 11'(MIN_FRAME)) && (cnt_reg <= 11'(MAX_FRAME));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_WAIT_IDLE;
      h_fifo_din    <= '0;
      h_fifo_wren   <= 1'b0;
      b_fifo_din    <= '0;
      b_fifo_del_in <= 1'b0;
      b_fifo_wren   <= 1'b0;
      ctrl_frame    <= 1'b0;
      drop_frame    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      h_fifo_din    <= h_din_next;
      h_fifo_wren   <= h_wren_next;
      b_fifo_din    <= b_din_next;
      b_fifo_del_in <= b_del_next;
      b_fifo_wren   <= b_wren_next;
      ctrl_frame    <= ctrl_next;
      drop_frame    <= drop_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_WAIT_IDLE: if (!rx_dv) state_next = S_IDLE;
      S_IDLE:      if (rx_dv) state_next = admit ? S_HDR : S_DROP;
      S_HDR: begin
        if (!rx_dv)                          state_next = S_FLUSH;
        else if (take && cnt_reg == 11'd13)  state_next = S_BODY;
      end
      S_BODY:      if (!rx_dv) state_next = S_FLUSH;
      S_FLUSH:     state_next = S_HWRITE;
      S_HWRITE: begin
        if (rx_dv) state_next = admit ? S_HDR : S_DROP;
        else       state_next = S_IDLE;
      end
      S_DROP:      if (!rx_dv) state_next = S_IDLE;
      default:     state_next = S_WAIT_IDLE;
    endcase
  end

  always_comb begin
    h_din_next  = '0;
    h_wren_next = 1'b0;
    b_din_next  = '0;
    b_del_next  = 1'b0;
    b_wren_next = 1'b0;
    ctrl_next   = 1'b0;
    drop_next   = 1'b0;
    case (state_reg)
      S_IDLE: drop_next = rx_dv && !admit;
      S_BODY: begin
        if (take && line_full && !ctrl_reg) begin
          b_wren_next = 1'b1;
          b_din_next  = line_reg[0];
        end
      end
      S_FLUSH: begin
        // Oldest held byte is the last payload byte; a dummy 0x00 keeps the delimiter contract.
        if (!ctrl_reg) begin
          b_wren_next = 1'b1;
          b_del_next  = 1'b1;
          b_din_next  = line_full ? line_reg[0] : 8'h00;
        end
      end
      S_HWRITE: begin
        drop_next   = rx_dv && !admit;
        ctrl_next   = ctrl_reg;
        h_wren_next = !ctrl_reg;
        if (!ctrl_reg) begin
          h_din_next[115]     = frame_valid;
          h_din_next[113:112] = PORT;
          h_din_next[111:0]   = hdr_reg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_reg      <= '0;
      cnt_reg      <= '0;
      crc_reg      <= CRC_INIT;
      er_reg       <= 1'b0;
      ctrl_reg     <= 1'b0;
      line_cnt_reg <= '0;
      for (int i = 0; i < 5; i++) line_reg[i] <= '0;
    end else begin
      if (start) begin
        crc_reg      <= rx_valid ? crc_byte(CRC_INIT, rx_data) : CRC_INIT;
        cnt_reg      <= {10'd0, rx_valid};
        er_reg       <= rx_er;
        ctrl_reg     <= 1'b0;
        line_cnt_reg <= '0;
      end else if (take) begin
        crc_reg <= crc_byte(crc_reg, rx_data);
        if (cnt_reg != 11'h7FF) cnt_reg <= cnt_reg + 11'd1;
      end
      if (!start && rx_dv && rx_er && (state_reg == S_HDR || state_reg == S_BODY))
        er_reg <= 1'b1;
      if (take && (start || state_reg == S_HDR)) begin
        hdr_reg <= {hdr_reg[103:0], rx_data};
        // DST completes with byte 5, well before the first body write can happen.
        if (!start && cnt_reg == 11'd5)
          ctrl_reg <= ({hdr_reg[39:0], rx_data[7:4]} == CTRL_DST_HI);
      end
      if (take && state_reg == S_BODY) begin
        for (int i = 0; i < 4; i++) line_reg[i] <= line_reg[i+1];
        line_reg[4] <= rx_data;
        if (!line_full) line_cnt_reg <= line_cnt_reg + 3'd1;
      end
    end
  end

endmodule
